// File: rtl/sd_resp_receiver_if.sv
// sd_resp_receiver_if
// Bundles the command-transmitter handshake, the serial CMD sample path and
// the response register / status outputs of the SD response receiver.
//   master : command transmitter side (drives start, resp_type, cmd_index,
//            bit_en, cmd_in; observes response data and status)
//   slave  : the response receiver itself
interface sd_resp_receiver_if;
    logic        bit_en;
    logic        cmd_in;
    logic        start;
    logic [1:0]  resp_type;
    logic [5:0]  cmd_index;
    logic [31:0] resp0_out;
    logic [31:0] resp1_out;
    logic [31:0] resp2_out;
    logic [31:0] resp3_out;
    logic        resp_we;
    logic        done;
    logic        busy;
    logic        timeout_err;
    logic        crc_err;
    logic        end_bit_err;
    logic        index_err;

    modport master (
        output bit_en, cmd_in, start, resp_type, cmd_index,
        input  resp0_out, resp1_out, resp2_out, resp3_out,
        input  resp_we, done, busy, timeout_err, crc_err, end_bit_err, index_err
    );

    modport slave (
        input  bit_en, cmd_in, start, resp_type, cmd_index,
        output resp0_out, resp1_out, resp2_out, resp3_out,
        output resp_we, done, busy, timeout_err, crc_err, end_bit_err, index_err
    );
endinterface

// File: rtl/sd_resp_receiver.sv
// sd_resp_receiver
// Deframes SD card responses (48-bit R1/R3/R6/R7, 136-bit R2) from the CMD
// line, checks CRC7 / end bit / index and writes the Response 0-3 registers.
// Ports:
//   ex_clk     system clock, rising edge
//   ex_resetn  asynchronous active-low reset
//   bus        sd_resp_receiver_if.slave: bit_en/cmd_in sample path,
//              start/resp_type/cmd_index from the command transmitter,
//              resp0..3_out + resp_we, done/busy and sticky error flags
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start from the command transmitter
// WAIT_START | counting high CMD samples until a start bit or timeout
// RECV       | shifting in frame bits, running CRC7
// FINISH     | one-cycle done pulse, busy drops
module sd_resp_receiver #(
    parameter int NCR_MAX = 64
) (
    input  logic               ex_clk,
    input  logic               ex_resetn,
    sd_resp_receiver_if.slave  bus
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_RECV       = 2'd2;
    localparam logic [1:0] S_FINISH     = 2'd3;

    localparam logic [1:0] T_NONE  = 2'b00;
    localparam logic [1:0] T_SHORT = 2'b01;
    localparam logic [1:0] T_LONG  = 2'b10;
    localparam logic [1:0] T_R3    = 2'b11;

    localparam int                WAIT_W    = $clog2(NCR_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(NCR_MAX - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_resp_type;
    logic [5:0]        r_cmd_index;
    logic [7:0]        r_bit_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [6:0]        r_crc;
    // Only the last 133 received bits are ever read; the start and
    // transmission bits of a long frame fall off the top.
    logic [132:0]      r_shift;
    logic [31:0]       r_resp0, r_resp1, r_resp2, r_resp3;
    logic              r_resp_we, r_done, r_busy;
    logic              r_timeout_err, r_crc_err, r_end_bit_err, r_index_err;

    logic              w_long;
    logic [7:0]        w_bit_num;
    logic [7:0]        w_frame_len;
    logic              w_crc_cover;
    logic              w_crc_fb;
    logic [6:0]        w_crc_nxt;
    logic [133:0]      w_shift_nxt;
    logic              w_last;

    // w_bit_num is the 1-based frame position of the bit being sampled now;
    // after the last shift, frame bit k sits at w_shift_nxt[frame_len-k].
    assign w_long      = (r_resp_type == T_LONG);
    assign w_bit_num   = r_bit_cnt + 8'd1;
    assign w_frame_len = w_long ? 8'd136 : 8'd48;
    assign w_crc_cover = w_long ? ((w_bit_num >= 8'd9) && (w_bit_num <= 8'd128))
                                : (w_bit_num <= 8'd40);
    assign w_crc_fb    = r_crc[6] ^ bus.cmd_in;
    assign w_crc_nxt   = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);
    assign w_shift_nxt = {r_shift, bus.cmd_in};
    assign w_last      = (w_bit_num == w_frame_len);

    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_state       <= S_IDLE;
            r_resp_type   <= T_NONE;
            r_cmd_index   <= 6'd0;
            r_bit_cnt     <= 8'd0;
            r_wait_cnt    <= '0;
            r_crc         <= 7'd0;
            r_shift       <= '0;
            r_resp0       <= 32'h0;
            r_resp1       <= 32'h0;
            r_resp2       <= 32'h0;
            r_resp3       <= 32'h0;
            r_resp_we     <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_crc_err     <= 1'b0;
            r_end_bit_err <= 1'b0;
            r_index_err   <= 1'b0;
        end else begin
            r_resp_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_resp_type   <= bus.resp_type;
                        r_cmd_index   <= bus.cmd_index;
                        r_timeout_err <= 1'b0;
                        r_crc_err     <= 1'b0;
                        r_end_bit_err <= 1'b0;
                        r_index_err   <= 1'b0;
                        r_bit_cnt     <= 8'd0;
                        r_crc         <= 7'd0;
                        r_wait_cnt    <= WAIT_LOAD;
                        r_busy        <= 1'b1;
                        r_state       <= (bus.resp_type == T_NONE) ? S_FINISH : S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (bus.bit_en) begin
                        if (!bus.cmd_in) begin
                            r_bit_cnt <= 8'd1;
                            if (!w_long) begin
                                r_crc <= w_crc_nxt;
                            end
                            r_state <= S_RECV;
                        end else if (r_wait_cnt == '0) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= S_FINISH;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (bus.bit_en) begin
                        r_shift   <= w_shift_nxt[132:0];
                        r_bit_cnt <= w_bit_num;
                        if (w_crc_cover) begin
                            r_crc <= w_crc_nxt;
                        end
                        if (w_last) begin
                            r_resp_we     <= 1'b1;
                            r_end_bit_err <= ~bus.cmd_in;
                            r_crc_err     <= (r_resp_type != T_R3) && (w_shift_nxt[7:1] != r_crc);
                            r_resp0       <= w_shift_nxt[39:8];
                            if (w_long) begin
                                r_index_err <= (w_shift_nxt[133:128] != 6'h3F);
                                r_resp1     <= w_shift_nxt[71:40];
                                r_resp2     <= w_shift_nxt[103:72];
                                r_resp3     <= {8'h00, w_shift_nxt[127:104]};
                            end else begin
                                r_index_err <= (r_resp_type == T_SHORT) &&
                                               (w_shift_nxt[45:40] != r_cmd_index);
                            end
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.resp0_out   = r_resp0;
    assign bus.resp1_out   = r_resp1;
    assign bus.resp2_out   = r_resp2;
    assign bus.resp3_out   = r_resp3;
    assign bus.resp_we     = r_resp_we;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.crc_err     = r_crc_err;
    assign bus.end_bit_err = r_end_bit_err;
    assign bus.index_err   = r_index_err;
endmodule

// File: tb/tb_sd_resp_receiver.sv
// tb_sd_resp_receiver
// Directed cases for R1/R2/R3, CRC/index/end-bit errors, timeout, type 00 and
// mid-frame reset, followed by randomized transactions. Expected register and
// flag values come from a frame-level model of the response formats.
module tb_sd_resp_receiver;
    localparam int NCR_MAX = 64;

    logic ex_clk    = 1'b0;
    logic ex_resetn = 1'b0;

    sd_resp_receiver_if bus ();

    sd_resp_receiver #(.NCR_MAX(NCR_MAX)) dut (
        .ex_clk    (ex_clk),
        .ex_resetn (ex_resetn),
        .bus       (bus)
    );

    always #5 ex_clk = ~ex_clk;

    int          n_cmp    = 0;
    int          n_mis    = 0;
    int          we_cnt   = 0;
    int          done_cnt = 0;
    bit          noise_en = 1'b0;
    logic [31:0] exp_resp [4];

    // Pulse counters; sampled on the rising edge so each high cycle counts once.
    always @(posedge ex_clk) begin
        if (bus.resp_we === 1'b1) we_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 over 1-based frame positions lo..hi.
    function automatic logic [6:0] crc7(input bit frm[$], input int lo, input int hi);
        logic [6:0] c;
        bit         fb;
        c = 7'd0;
        for (int i = lo; i <= hi; i++) begin
            fb = c[6] ^ frm[i-1];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic chk_status(input string nm, input bit e_to, input bit e_crc,
                              input bit e_end, input bit e_idx);
        chk({nm, "_flags(to,crc,end,idx)"},
            128'({bus.timeout_err, bus.crc_err, bus.end_bit_err, bus.index_err}),
            128'({e_to, e_crc, e_end, e_idx}));
        chk({nm, "_resp"},
            {bus.resp3_out, bus.resp2_out, bus.resp1_out, bus.resp0_out},
            {exp_resp[3], exp_resp[2], exp_resp[1], exp_resp[0]});
    endtask

    // One bit period: a few idle cycles, then one bit_en strobe carrying b.
    // With noise enabled a start pulse (type 00) is occasionally overlaid;
    // the receiver is busy and must ignore it.
    task automatic send_bit(input bit b);
        repeat ($urandom_range(0, 2)) @(negedge ex_clk);
        bus.cmd_in = b;
        bus.bit_en = 1'b1;
        if (noise_en && ($urandom_range(0, 15) == 0)) begin
            bus.start     = 1'b1;
            bus.resp_type = 2'b00;
        end
        @(negedge ex_clk);
        bus.bit_en = 1'b0;
        bus.start  = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] typ, input logic [5:0] idx);
        bus.resp_type = typ;
        bus.cmd_index = idx;
        bus.start     = 1'b1;
        // A strobe coinciding with start must not be taken as a start bit.
        bus.bit_en    = 1'($urandom_range(0, 1));
        bus.cmd_in    = 1'b0;
        @(negedge ex_clk);
        bus.start  = 1'b0;
        bus.bit_en = 1'b0;
        bus.cmd_in = 1'b1;
    endtask

    // fld is the index field for 48-bit frames and the reserved field for 136-bit.
    task automatic run_txn(input string nm, input logic [1:0] typ, input logic [5:0] idx,
                           input logic [5:0] fld, input logic [119:0] payload, input int gap,
                           input bit flip_crc, input bit bad_end);
        bit         frm[$];
        logic [6:0] crc_calc, crc_sent;
        bit         is_long, e_crc, e_idx, e_we;
        is_long  = (typ == 2'b10);
        e_we     = 1'b0;
        we_cnt   = 0;
        done_cnt = 0;
        pulse_start(typ, idx);
        chk({nm, "_busy_rise"}, 128'(bus.busy), 128'(1));
        if (typ == 2'b00) begin
            chk({nm, "_done_early"}, 128'(bus.done), 128'(0));
            @(negedge ex_clk);
            chk({nm, "_done"}, 128'({bus.done, bus.busy}), 128'(2'b10));
            chk_status(nm, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (gap >= NCR_MAX) begin
            repeat (NCR_MAX) send_bit(1'b1);
            chk({nm, "_done_early"}, 128'(bus.done), 128'(0));
            chk_status(nm, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge ex_clk);
            chk({nm, "_done"}, 128'({bus.done, bus.busy}), 128'(2'b10));
        end else begin
            frm.push_back(1'b0);
            frm.push_back(1'($urandom_range(0, 1)));
            for (int i = 5; i >= 0; i--) frm.push_back(fld[i]);
            if (is_long) begin
                for (int i = 119; i >= 0; i--) frm.push_back(payload[i]);
                crc_calc = crc7(frm, 9, 128);
            end else begin
                for (int i = 31; i >= 0; i--) frm.push_back(payload[i]);
                crc_calc = crc7(frm, 1, 40);
            end
            if (typ == 2'b11) crc_sent = flip_crc ? 7'($urandom) : 7'h7F;
            else crc_sent = flip_crc ? (crc_calc ^ (7'd1 << $urandom_range(0, 6))) : crc_calc;
            for (int i = 6; i >= 0; i--) frm.push_back(crc_sent[i]);
            frm.push_back(!bad_end);

            e_we  = 1'b1;
            e_crc = (typ != 2'b11) && (crc_sent != crc_calc);
            e_idx = is_long ? (fld != 6'h3F) : ((typ == 2'b01) && (fld != idx));
            if (is_long) {exp_resp[3], exp_resp[2], exp_resp[1], exp_resp[0]} = {8'h00, payload};
            else exp_resp[0] = payload[31:0];

            repeat (gap) send_bit(1'b1);
            foreach (frm[i]) send_bit(frm[i]);
            chk({nm, "_we"}, 128'({bus.resp_we, bus.done}), 128'(2'b10));
            chk_status(nm, 1'b0, e_crc, bad_end, e_idx);
            @(negedge ex_clk);
            chk({nm, "_done"}, 128'({bus.done, bus.busy, bus.resp_we}), 128'(3'b100));
        end
        @(negedge ex_clk);
        chk({nm, "_pulse_counts"}, 128'({we_cnt[7:0], done_cnt[7:0]}), 128'({7'd0, e_we, 8'd1}));
    endtask

    initial begin
        logic [119:0] pl;
        logic [1:0]   typ;
        logic [5:0]   idx, fld;
        int           gap;

        bus.bit_en    = 1'b0;
        bus.cmd_in    = 1'b1;
        bus.start     = 1'b0;
        bus.resp_type = 2'b00;
        bus.cmd_index = 6'd0;
        for (int i = 0; i < 4; i++) exp_resp[i] = 32'h0;

        repeat (3) @(negedge ex_clk);
        chk("reset_ctl", 128'({bus.busy, bus.done, bus.resp_we}), 128'(0));
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        ex_resetn = 1'b1;
        @(negedge ex_clk);

        run_txn("r1",      2'b01, 6'd17, 6'd17, 120'h900, 5, 1'b0, 1'b0);
        run_txn("r1_crc",  2'b01, 6'd17, 6'd17, 120'h900, 5, 1'b1, 1'b0);
        run_txn("r1_idx",  2'b01, 6'd17, 6'd18, 120'h900, 5, 1'b0, 1'b0);
        run_txn("r2",      2'b10, 6'd2,  6'h3F, 120'h0123456789ABCDEF0123456789ABEF, 3, 1'b0, 1'b0);
        run_txn("r3",      2'b11, 6'd41, 6'h3F, 120'h80FF8000, 2, 1'b0, 1'b0);
        run_txn("timeout", 2'b01, 6'd17, 6'd17, 120'h1234, NCR_MAX, 1'b0, 1'b0);
        run_txn("type00",  2'b00, 6'd0,  6'd0,  120'h0, 0, 1'b0, 1'b0);
        run_txn("endbit",  2'b01, 6'd8,  6'd8,  120'hCAFE0001, 1, 1'b0, 1'b1);
        run_txn("ncr63",   2'b01, 6'd9,  6'd9,  120'h5A5A5A5A, NCR_MAX - 1, 1'b0, 1'b0);

        // Reset at bit 20 of an R1 frame.
        pulse_start(2'b01, 6'd17);
        repeat (5) send_bit(1'b1);
        send_bit(1'b0);
        repeat (19) send_bit(1'($urandom_range(0, 1)));
        ex_resetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_resp[i] = 32'h0;
        chk("midrst_ctl", 128'({bus.busy, bus.done, bus.resp_we}), 128'(0));
        chk_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge ex_clk);
        ex_resetn = 1'b1;
        @(negedge ex_clk);
        run_txn("after_rst", 2'b01, 6'd17, 6'd17, 120'h900, 5, 1'b0, 1'b0);

        noise_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            typ = 2'($urandom_range(0, 3));
            idx = 6'($urandom);
            pl  = {$urandom, $urandom, $urandom, $urandom};
            if (typ == 2'b10) fld = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h3F;
            else if (typ == 2'b01) fld = ($urandom_range(0, 5) == 0) ? 6'($urandom) : idx;
            else fld = 6'($urandom);
            gap = ($urandom_range(0, 9) == 0) ? NCR_MAX : $urandom_range(0, 12);
            run_txn("rand", typ, idx, fld, pl, gap,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sd_resp_receiver.md
# sd_resp_receiver

Receives SD card responses serially on the CMD line after the host issues a command. It deframes the 48-bit response formats (R1/R3/R6/R7) and the 136-bit format (R2), checks the CRC7, end bit and index, and drives the Response 0–3 register write path in the register bank. It also raises completion and error flags for the normal and error interrupt status logic. It sits in the host datapath beside the command transmitter, clocked by the gated internal clock domain's source clock.

## Interface
- NCR_MAX, 64, bit periods to wait for a start bit before flagging timeout.
- ex_clk  input  1  system clock; all state changes on rising edge.
- ex_resetn  input  1  asynchronous, active-low reset.
- bit_en  input  1  one-cycle strobe per SD clock period; CMD line is sampled only when high.
- cmd_in  input  1  serial CMD line from the card; idles high.
- start  input  1  one-cycle pulse from the command transmitter after the command end bit is sent.
- resp_type  input  2  latched on start:
  - 00 = no response
  - 01 = 48-bit with CRC/index check
  - 10 = 136-bit
  - 11 = 48-bit, no CRC/index check (R3)
- cmd_index  input  6  expected index; latched on start.
- resp0_out, resp1_out, resp2_out, resp3_out  output  32  response register data.
- resp_we  output  1  one-cycle write strobe for resp0–3 (maps to resp0_en..resp3_en).
- done  output  1  one-cycle pulse at end of transaction (Command Complete).
- busy  output  1  high from start until done.
- timeout_err, crc_err, end_bit_err, index_err  output  1 each  sticky error flags; cleared on next start.

## Operation
- States: IDLE, WAIT_START, RECV, FINISH.
- IDLE, start=1:
  - latch resp_type and cmd_index;
  - clear all error flags, the bit counter and the CRC;
  - if resp_type=00, go to FINISH; otherwise go to WAIT_START.
- WAIT_START, on each bit_en:
  - cmd_in=0: start bit found; go to RECV with bit count 1. The start bit is fed into the CRC.
  - cmd_in=1: increment the wait counter. When it reaches NCR_MAX, set timeout_err and go to FINISH.
- RECV, each bit_en: shift cmd_in into a 136-bit shift register and increment the 8-bit bit counter. Frame lengths are 48 and 136 bits, including the start bit.
- CRC7, poly x^7+x^3+1, init 0. Per bit: fb = crc[6]^b; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0).
  - 48-bit coverage: bits 1–40 (start, transmission, index, argument).
  - 136-bit coverage: content bits 9–128 only. The start, transmission and the six reserved '1' bits are excluded.
  - The next 7 bits are compared against the computed CRC; a mismatch sets crc_err. resp_type=11 skips this check.
- End bit: the last bit must be 1, else set end_bit_err.
- Transmission bit (bit 2) value is ignored.
- Index:
  - resp_type=01: index field ≠ cmd_index sets index_err.
  - resp_type=10: index field ≠ 6'h3F sets index_err.
  - resp_type=11: no check.
- Register mapping:
  - 48-bit: resp0_out = argument bits[39:8] of the frame; resp1–3 unchanged.
  - 136-bit: {resp3,resp2,resp1,resp0} = {8'h00, R[127:8]}, where R[127:1] is content and CRC after the reserved bits.
  - Registers are updated on the final bit even when errors are flagged; no update on timeout or on type 00.
- FINISH: pulse done for one cycle, drop busy, return to IDLE.
- start while busy is ignored.
- A bit_en that falls in the same cycle as start is not sampled.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, resp_we=0;
  - all errors 0; resp0–3_out = 32'h0;
  - counters and CRC 0.
- busy rises the cycle after start.
- The cycle after the bit_en that samples the end bit:
  - resp_we=1 and the error flags are valid;
  - done pulses one cycle later;
  - busy falls with done.
- Type 00: done pulses 2 cycles after start.
- Timeout: done pulses the cycle after the NCR_MAX-th high sample.
- Asynchronous reset mid-frame returns to IDLE immediately. No partial register write occurs.
- Error flags hold until the next accepted start.

## Test plan
- R1 test:
  - Stimulus: start, type 01, index 17; card sends frame 0|0|010001|32'h00000900|bench-computed CRC7|1 after 5 idle bits.
  - Required response: resp0_out=32'h00000900, resp_we pulses once, done pulses once, no errors.
- Same frame with one CRC bit flipped -> crc_err=1, resp0 still updated; frame with index 18 -> index_err=1.
- R2 test:
  - Stimulus: type 10; card sends CSD content 120'h0123…EF followed by a valid CRC7.
  - Required response: {resp3..resp0} = {8'h00, content}, no errors.
- R3 test:
  - Stimulus: type 11; index bits 111111, CRC bits 1111111, argument 32'h80FF8000.
  - Required response: resp0=32'h80FF8000, no crc_err, no index_err.
- Timeout test:
  - Stimulus: cmd_in held high for 64 bit_en strobes.
  - Required response: timeout_err=1, done pulses, resp registers unchanged.
- Type 00 -> done 2 cycles after start.
- Reset test: assert ex_resetn=0 at bit 20 of an R1 frame -> all outputs 0, state IDLE; a subsequent transaction completes cleanly.
- End-bit test: final bit driven 0 -> end_bit_err=1.
